// File: rtl/csb_master_falcon2csb_fifo.sv
// Response FIFO on the falcon-to-CSB return path: flop storage, valid/busy
// handshake on both sides, occupancy count and idle flag for clock gating.
module csb_master_falcon2csb_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset_,
  input  logic                         wr_req,
  output logic                         wr_busy,
  input  logic [WIDTH-1:0]             wr_data,
  output logic                         rd_req,
  input  logic                         rd_busy,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   wr_count,
  output logic                         fifo_idle,
  input  logic [31:0]                  pwrbus_ram_pd
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [AW-1:0] LAST_ADR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] ram [DEPTH];
  logic [AW-1:0]    wr_adr;
  logic [AW-1:0]    rd_adr;
  logic             push;
  logic             pop;
  logic             unused_pwrbus;

  // Explicit wrap so non-power-of-two depths never walk past the last entry.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    return (ptr == LAST_ADR) ? '0 : ptr + AW'(1);
  endfunction

  assign wr_busy   = (wr_count == FULL_CNT);
  assign rd_req    = (wr_count != '0);
  assign push      = wr_req & ~wr_busy;
  assign pop       = rd_req & ~rd_busy;
  assign rd_data   = ram[rd_adr];
  assign fifo_idle = (wr_count == '0) & ~wr_req;

  assign unused_pwrbus = ^pwrbus_ram_pd;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_adr   <= '0;
      rd_adr   <= '0;
      wr_count <= '0;
    end else begin
      if (push) begin
        wr_adr <= next_ptr(wr_adr);
      end
      if (pop) begin
        rd_adr <= next_ptr(rd_adr);
      end
      if (push && !pop) begin
        wr_count <= wr_count + CW'(1);
      end else if (pop && !push) begin
        wr_count <= wr_count - CW'(1);
      end
    end
  end

  // Payload flops carry no reset; rd_req gates their meaning.
  always_ff @(posedge clk) begin
    if (push) begin
      ram[wr_adr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_csb_master_falcon2csb_fifo.sv
// Bench for the falcon2csb response FIFO: two instances (DEPTH 2 and 3) driven
// by directed steps, with a scoreboard queue of accepted packets per instance.
module tb_csb_master_falcon2csb_fifo;

  localparam int W  = 34;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset_;
  logic          wr_req    [2];
  logic          rd_busy   [2];
  logic [W-1:0]  wr_data   [2];
  logic          wr_busy   [2];
  logic          rd_req    [2];
  logic          fifo_idle [2];
  logic [W-1:0]  rd_data   [2];
  logic [CW-1:0] wr_count  [2];
  logic [31:0]   pwrbus = '0;

  int            depth [2] = '{2, 3};
  int            model_count [2];
  logic [W-1:0]  sb0 [$];
  logic [W-1:0]  sb1 [$];
  int            checks = 0;
  int            passes = 0;
  int            fails  = 0;

  always #5 clk = ~clk;

  csb_master_falcon2csb_fifo #(.WIDTH(W), .DEPTH(2)) u_dut2 (
    .clk           (clk),
    .reset_        (reset_),
    .wr_req        (wr_req[0]),
    .wr_busy       (wr_busy[0]),
    .wr_data       (wr_data[0]),
    .rd_req        (rd_req[0]),
    .rd_busy       (rd_busy[0]),
    .rd_data       (rd_data[0]),
    .wr_count      (wr_count[0]),
    .fifo_idle     (fifo_idle[0]),
    .pwrbus_ram_pd (pwrbus)
  );

  csb_master_falcon2csb_fifo #(.WIDTH(W), .DEPTH(3)) u_dut3 (
    .clk           (clk),
    .reset_        (reset_),
    .wr_req        (wr_req[1]),
    .wr_busy       (wr_busy[1]),
    .wr_data       (wr_data[1]),
    .rd_req        (rd_req[1]),
    .rd_busy       (rd_busy[1]),
    .rd_data       (rd_data[1]),
    .wr_count      (wr_count[1]),
    .fifo_idle     (fifo_idle[1]),
    .pwrbus_ram_pd (pwrbus)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] sb_front(input int d);
    return (d == 0) ? sb0[0] : sb1[0];
  endfunction

  task automatic sb_pop(input int d);
    if (d == 0) void'(sb0.pop_front());
    else        void'(sb1.pop_front());
  endtask

  task automatic sb_push(input int d, input logic [W-1:0] v);
    if (d == 0) sb0.push_back(v);
    else        sb1.push_back(v);
  endtask

  task automatic model_reset();
    sb0.delete();
    sb1.delete();
    model_count[0] = 0;
    model_count[1] = 0;
  endtask

  // Status outputs against the bench's own occupancy model.
  task automatic check_output(input int d, input logic wreq);
    int mc;
    mc = model_count[d];
    check($sformatf("d%0d rd_req", d),    W'(rd_req[d]),    W'(mc != 0));
    check($sformatf("d%0d wr_busy", d),   W'(wr_busy[d]),   W'(mc == depth[d]));
    check($sformatf("d%0d wr_count", d),  W'(wr_count[d]),  W'(mc));
    check($sformatf("d%0d fifo_idle", d), W'(fifo_idle[d]), W'((mc == 0) && !wreq));
    check($sformatf("d%0d count_bound", d), W'(int'(wr_count[d]) <= depth[d]), W'(1));
  endtask

  // One clock cycle: drive just after the edge, check at the falling edge.
  task automatic apply_stimulus(input int d, input logic wreq, input logic [W-1:0] wdata,
                                input logic rbusy);
    logic exp_push;
    logic exp_pop;
    wr_req[d]  = wreq;
    wr_data[d] = wdata;
    rd_busy[d] = rbusy;
    @(negedge clk);
    check_output(d, wreq);
    exp_pop  = !rbusy && (model_count[d] != 0);
    exp_push = wreq && (model_count[d] != depth[d]);
    if (model_count[d] != 0) begin
      check($sformatf("d%0d rd_data", d), rd_data[d], sb_front(d));
    end
    if (exp_pop)  sb_pop(d);
    if (exp_push) sb_push(d, wdata);
    model_count[d] = model_count[d] + int'(exp_push) - int'(exp_pop);
    @(posedge clk);
    #1;
  endtask

  task automatic run_suite(input int d);
    logic [W-1:0] base;
    base = (d == 0) ? 34'h0_1000_0000 : 34'h1_2000_0000;

    $display("[TB] DEPTH=%0d: single packet", depth[d]);
    apply_stimulus(d, 1'b1, 34'h2_DEADBEEF, 1'b0);
    apply_stimulus(d, 1'b0, '0, 1'b0);
    apply_stimulus(d, 1'b0, '0, 1'b0);

    $display("[TB] DEPTH=%0d: fill with stalled reader", depth[d]);
    for (int i = 1; i <= depth[d] + 1; i++) begin
      apply_stimulus(d, 1'b1, W'(i), 1'b1);
    end
    for (int i = 0; i <= depth[d]; i++) begin
      apply_stimulus(d, 1'b0, '0, 1'b0);
    end

    $display("[TB] DEPTH=%0d: streaming push/pop at count 1", depth[d]);
    apply_stimulus(d, 1'b1, base, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      apply_stimulus(d, 1'b1, base + W'(i), 1'b0);
    end
    apply_stimulus(d, 1'b0, '0, 1'b0);
    apply_stimulus(d, 1'b0, '0, 1'b0);

    $display("[TB] DEPTH=%0d: full plus pop with held writer", depth[d]);
    for (int i = 0; i < depth[d]; i++) begin
      apply_stimulus(d, 1'b1, base + W'(16 + i), 1'b1);
    end
    apply_stimulus(d, 1'b1, base + W'(32), 1'b0);
    apply_stimulus(d, 1'b1, base + W'(32), 1'b0);
    for (int i = 0; i < depth[d]; i++) begin
      apply_stimulus(d, 1'b0, '0, 1'b0);
    end
    apply_stimulus(d, 1'b0, '0, 1'b0);

    $display("[TB] DEPTH=%0d: async reset mid-stream", depth[d]);
    apply_stimulus(d, 1'b1, base + W'(48), 1'b1);
    apply_stimulus(d, 1'b1, base + W'(49), 1'b1);
    check($sformatf("d%0d pre_reset rd_req", d), W'(rd_req[d]), W'(1));
    #2;
    reset_ = 1'b0;
    #1;
    check($sformatf("d%0d async rd_req", d),   W'(rd_req[d]),   W'(0));
    check($sformatf("d%0d async wr_count", d), W'(wr_count[d]), W'(0));
    check($sformatf("d%0d async wr_busy", d),  W'(wr_busy[d]),  W'(0));
    model_reset();
    wr_req[d]  = 1'b0;
    rd_busy[d] = 1'b0;
    @(negedge clk);
    reset_ = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(d, 1'b0, '0, 1'b0);
    apply_stimulus(d, 1'b1, base + W'(64), 1'b0);
    apply_stimulus(d, 1'b0, '0, 1'b0);
    apply_stimulus(d, 1'b0, '0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    model_reset();
    for (int i = 0; i < 2; i++) begin
      wr_req[i]  = 1'b1;
      rd_busy[i] = 1'b0;
      wr_data[i] = '0;
    end
    reset_ = 1'b0;

    $display("[TB] reset state with wr_req held high");
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("d%0d reset wr_busy", i),   W'(wr_busy[i]),   W'(0));
      check($sformatf("d%0d reset rd_req", i),    W'(rd_req[i]),    W'(0));
      check($sformatf("d%0d reset wr_count", i),  W'(wr_count[i]),  W'(0));
      check($sformatf("d%0d reset fifo_idle", i), W'(fifo_idle[i]), W'(0));
      wr_req[i]  = 1'b0;
      rd_busy[i] = 1'b1;
    end
    @(negedge clk);
    reset_ = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("d%0d release fifo_idle", i), W'(fifo_idle[i]), W'(1));
    end

    run_suite(0);
    run_suite(1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/csb_master_falcon2csb_fifo.md
Name: csb_master_falcon2csb_fifo

Overview:
- Single-clock response FIFO carrying falcon-to-CSB read-data and write-ack packets back to the CSB master. It is the return path of the csb2falcon request FIFO.
- Flop-based storage with a valid/busy handshake on both sides. An occupancy count and an idle flag feed the CSB master's power and clock-gating logic.
- Sits between the falcon response port (write side) and the CSB master response mux (read side).

Parameters:
- WIDTH, 34, packet width in bits (data plus 2 status bits).
- DEPTH, 2, number of entries; any value >= 2 is legal, power of two not required.

Ports:
- clk  input  1  core clock; all flops on rising edge.
- reset_  input  1  asynchronous, active-low reset.
- wr_req  input  1  write side: packet valid.
- wr_busy  output  1  write side: FIFO cannot accept a packet.
- wr_data  input  WIDTH  write side: packet payload.
- rd_req  output  1  read side: packet available.
- rd_busy  input  1  read side: consumer stall.
- rd_data  output  WIDTH  read side: head-of-queue payload.
- wr_count  output  $clog2(DEPTH+1)  current occupancy.
- fifo_idle  output  1  FIFO empty and no write in flight.
- pwrbus_ram_pd  input  32  RAM power-down bus; accepted and left unused.

Behaviour:
- Reset (asynchronous assert, synchronous release): wr_count=0, wr_adr=0, rd_adr=0, rd_req=0, wr_busy=0, fifo_idle=1. Storage flops are not reset; rd_data is don't-care while rd_req=0.
- Push = wr_req & ~wr_busy. Pop = rd_req & ~rd_busy.
- wr_busy = (wr_count == DEPTH), taken from a registered count; combinational in count only, never in wr_req.
- rd_req = (wr_count != 0).
- rd_data = ram[rd_adr], a combinational mux from flops.
- Push: ram[wr_adr] <= wr_data at the edge; wr_adr advances.
- Pop: rd_adr advances.
- Pointer wrap: when ptr == DEPTH-1 it goes to 0, otherwise ptr+1. This must hold for non-power-of-two DEPTH.
- Count update:
  - push & ~pop: +1.
  - pop & ~push: -1.
  - both or neither: unchanged.
- Latency: a packet written at edge N is visible on rd_req/rd_data after edge N, i.e. 1 cycle. There is no same-cycle write-to-read bypass.
- Full: wr_busy=1, so no push. A pop in the same cycle frees a slot, but wr_busy deasserts only on the following cycle (no full-cycle pass-through).
- Empty: rd_req=0. A write in that cycle is not readable until the next cycle.
- Simultaneous push and pop when 0 < count < DEPTH: both pointers advance and count holds. If wr_adr == rd_adr after wrap, ordering is preserved.
- Stall: while rd_req=1 and rd_busy=1, rd_data and rd_req are stable.
- wr_req while wr_busy=1: the packet is ignored and the writer must hold it.
- fifo_idle = (wr_count == 0) & ~wr_req.
- Reset asserted mid-operation: all contents are discarded immediately. Outputs go to reset values asynchronously, with no partial pop or push.
- Count never exceeds DEPTH and never underflows. Checked by assertion in the bench.

Test Plan:
- Reset: hold reset_=0 and drive wr_req=1 -> wr_busy=0, rd_req=0, wr_count=0, fifo_idle=0 (wr_req high). Release reset with wr_req=0 -> fifo_idle=1.
- Single packet: push 0x2_DEADBEEF at edge N, rd_busy=0 -> rd_req=1 and rd_data=0x2_DEADBEEF in cycle N+1. Pop at N+1 -> rd_req=0 and wr_count=0 at N+2.
- Fill (DEPTH=2, rd_busy=1): push 0x1, 0x2 -> wr_count=2, wr_busy=1. A third push of 0x3 is ignored. Release rd_busy -> reads return 0x1 then 0x2 only.
- Simultaneous push/pop at count=1, over 10 cycles with incrementing data -> wr_count stays 1, output order is exact, and pointer wrap is exercised.
- Full plus pop: at count=2 assert pop and wr_req together -> no write that cycle. Next cycle wr_busy=0 and the held packet is accepted.
- Async reset mid-stream at count=2, asserted between edges -> rd_req falls without waiting for an edge. After release, wr_count=0 and no stale data is delivered. Repeat with DEPTH=3 to cover non-power-of-two wrap.
